// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared encodings, default vectors and counter helper for pc_gen
//   STRONG_NT/WEAK_NT/WEAK_T/STRONG_T : 2-bit BTB counter encodings (bit 1 = predict taken)
//   RESET_VEC_DEFAULT, TRAP_VEC_DEFAULT : default parameter values for pc_gen
//   ctr_update()                        : saturating counter step toward the resolved direction
package pc_gen_pkg;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEFAULT  = 32'h0000_0100;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == STRONG_T) ? STRONG_T : ctr + 2'b01;
        end
        return (ctr == STRONG_NT) ? STRONG_NT : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/pc_gen_btb.sv
// rtl/pc_gen_btb.sv - direct-mapped branch target buffer with 2-bit counters
//   clk, rst          : clock, synchronous active-high reset (clears valid, counters to WEAK_NT)
//   lookup_pc         : PC being looked up (combinational read port)
//   hit, ctr, target  : lookup result; ctr/target are raw entry contents
//   upd_valid, upd_pc, upd_target, upd_taken : synchronous training port
module pc_gen_btb import pc_gen_pkg::*; #(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            hit,
    output logic [1:0]      ctr,
    output logic [XLEN-1:0] target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken
);

    localparam int IDX   = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX - 2;

    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
    logic [XLEN-1:0]      target_q [BTB_DEPTH];
    logic [1:0]           ctr_q    [BTB_DEPTH];

    logic [IDX-1:0]   l_idx;
    logic [IDX-1:0]   u_idx;
    logic [TAG_W-1:0] l_tag;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    // Instruction PCs are word aligned; the two low bits never take part in indexing.
    logic [1:0] unused_lsbs;
    assign unused_lsbs = lookup_pc[1:0] ^ upd_pc[1:0];

    assign l_idx = lookup_pc[IDX+1:2];
    assign l_tag = lookup_pc[XLEN-1:IDX+2];
    assign u_idx = upd_pc[IDX+1:2];
    assign u_tag = upd_pc[XLEN-1:IDX+2];

    // Reads see the pre-update contents; a write lands at the edge.
    assign hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign ctr    = ctr_q[l_idx];
    assign target = target_q[l_idx];
    assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                ctr_q[i] <= WEAK_NT;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                ctr_q[u_idx] <= ctr_update(ctr_q[u_idx], upd_taken);
                if (upd_taken) begin
                    target_q[u_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                // Only taken outcomes allocate; a not-taken miss leaves the entry alone.
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target;
                ctr_q[u_idx]    <= WEAK_T;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC register with redirect/stall/prediction/PC+4 next-PC selection
//   Optional macro PC_GEN_MISALIGN_EN: misaligned redirects trap to TRAP_VEC with a
//   one-cycle misalign pulse, and BTB updates with misaligned targets are dropped.
//   clk, rst                    : clock, synchronous active-high reset
//   stall                       : hold pc
//   redirect_valid, redirect_pc : corrected next PC from EX (beats stall)
//   upd_valid, upd_pc, upd_target, upd_taken : BTB training from EX
//   pc                          : registered fetch PC
//   pred_taken, pred_target     : prediction for pc (pred_target = pc+4 when not taken)
//   misalign                    : registered trap pulse (0 unless PC_GEN_MISALIGN_EN)
module pc_gen import pc_gen_pkg::*; #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT),
    parameter int              BTB_DEPTH = 16,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            misalign
);

    logic            btb_hit;
    logic [1:0]      btb_ctr;
    logic [XLEN-1:0] btb_target;
    logic            upd_accept;
    logic [XLEN-1:0] pc_next;
    logic            misalign_next;

    pc_gen_btb #(
        .XLEN      (XLEN),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .lookup_pc  (pc),
        .hit        (btb_hit),
        .ctr        (btb_ctr),
        .target     (btb_target),
        .upd_valid  (upd_accept),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken)
    );

    assign pred_taken  = btb_hit && btb_ctr[1];
    assign pred_target = pred_taken ? btb_target : pc + XLEN'(4);

`ifdef PC_GEN_MISALIGN_EN
    assign upd_accept = upd_valid && (upd_target[1:0] == 2'b00);
`else
    assign upd_accept = upd_valid;
`endif

    always_comb begin
        pc_next       = pred_target;
        misalign_next = 1'b0;
        if (redirect_valid) begin
`ifdef PC_GEN_MISALIGN_EN
            if (redirect_pc[1:0] != 2'b00) begin
                pc_next       = TRAP_VEC;
                misalign_next = 1'b1;
            end else begin
                pc_next = redirect_pc;
            end
`else
            pc_next = redirect_pc;
`endif
        end else if (stall) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VEC;
        end else begin
            pc <= pc_next;
        end
    end

`ifdef PC_GEN_MISALIGN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= misalign_next;
        end
    end
`else
    logic [XLEN:0] unused_trap;
    assign unused_trap = {misalign_next, TRAP_VEC};
    assign misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - table-driven self-checking bench for pc_gen
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        misalign;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .misalign       (misalign)
    );

    typedef struct {
        logic        chk;
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        ut;
        logic [31:0] epc;
        logic        ept;
        logic [31:0] etgt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic chk, input logic r, input logic st, input logic rv,
                       input logic [31:0] rpc, input logic uv, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic ut, input logic [31:0] epc,
                       input logic ept, input logic [31:0] etgt);
        vec_t v;
        v.chk = chk; v.rst = r; v.stall = st; v.rv = rv; v.rpc = rpc;
        v.uv = uv; v.upc = upc; v.utgt = utgt; v.ut = ut;
        v.epc = epc; v.ept = ept; v.etgt = etgt;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst            = v.rst;
        stall          = v.stall;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        upd_valid      = v.uv;
        upd_pc         = v.upc;
        upd_target     = v.utgt;
        upd_taken      = v.ut;
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;

        // chk rst stl rv rpc            uv upc    utgt   ut   exp_pc          pt exp_tgt
        add(0, 1, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0, 32'h0,          0, 32'h0);
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0, 32'h0,          0, 32'h4);
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0, 32'h4,          0, 32'h8);
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0, 32'h8,          0, 32'hC);
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0, 32'hC,          0, 32'h10);
        add(1, 0, 1, 0, 32'h0,          0, 32'h0,  32'h0,   0, 32'h10,         0, 32'h14);
        add(1, 0, 1, 0, 32'h0,          0, 32'h0,  32'h0,   0, 32'h10,         0, 32'h14);
        add(1, 0, 1, 1, 32'h80,         0, 32'h0,  32'h0,   0, 32'h10,         0, 32'h14);
        add(1, 0, 0, 1, 32'h18,         1, 32'h20, 32'h100, 1, 32'h80,         0, 32'h84);
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0, 32'h18,         0, 32'h1C);
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0, 32'h1C,         0, 32'h20);
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0, 32'h20,         1, 32'h100);
        add(1, 0, 0, 0, 32'h0,          1, 32'h20, 32'h0,   0, 32'h100,        0, 32'h104);
        add(1, 0, 0, 1, 32'h20,         1, 32'h20, 32'h0,   0, 32'h104,        0, 32'h108);
        add(1, 0, 0, 0, 32'h0,          1, 32'h20, 32'h100, 1, 32'h20,         0, 32'h24);
        add(1, 0, 0, 0, 32'h0,          1, 32'h20, 32'h100, 1, 32'h24,         0, 32'h28);
        add(1, 0, 0, 0, 32'h0,          1, 32'h20, 32'h100, 1, 32'h28,         0, 32'h2C);
        add(1, 0, 0, 0, 32'h0,          1, 32'h20, 32'h100, 1, 32'h2C,         0, 32'h30);
        add(1, 0, 0, 1, 32'h20,         1, 32'h20, 32'h0,   0, 32'h30,         0, 32'h34);
        add(1, 0, 0, 1, 32'h20,         1, 32'h20, 32'h0,   0, 32'h20,         1, 32'h100);
        add(1, 0, 0, 0, 32'h0,          1, 32'h20, 32'h100, 1, 32'h20,         0, 32'h24);
        add(1, 0, 0, 1, 32'h20,         0, 32'h0,  32'h0,   0, 32'h24,         0, 32'h28);
        add(1, 0, 0, 0, 32'h0,          1, 32'h20, 32'h200, 1, 32'h20,         1, 32'h100);
        add(1, 0, 0, 1, 32'h20,         0, 32'h0,  32'h0,   0, 32'h100,        0, 32'h104);
        add(1, 0, 0, 0, 32'h0,          1, 32'h60, 32'h300, 1, 32'h20,         1, 32'h200);
        add(1, 0, 0, 1, 32'h20,         0, 32'h0,  32'h0,   0, 32'h200,        0, 32'h204);
        add(1, 0, 0, 1, 32'h60,         0, 32'h0,  32'h0,   0, 32'h20,         0, 32'h24);
        add(1, 1, 1, 1, 32'h44,         1, 32'h40, 32'h500, 1, 32'h60,         1, 32'h300);
        add(1, 0, 0, 1, 32'h60,         0, 32'h0,  32'h0,   0, 32'h0,          0, 32'h4);
        add(1, 0, 0, 1, 32'h40,         0, 32'h0,  32'h0,   0, 32'h60,         0, 32'h64);
        add(1, 0, 0, 1, 32'h40,         1, 32'h40, 32'h700, 0, 32'h40,         0, 32'h44);
        add(1, 0, 0, 1, 32'hFFFF_FFFC,  0, 32'h0,  32'h0,   0, 32'h40,         0, 32'h44);
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0, 32'hFFFF_FFFC,  0, 32'h0);
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0, 32'h0,          0, 32'h4);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            if (vecs[i].chk) begin
                check($sformatf("row%0d pc", i), pc, vecs[i].epc);
                check($sformatf("row%0d pred_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].ept});
                check($sformatf("row%0d pred_target", i), pred_target, vecs[i].etgt);
                check($sformatf("row%0d misalign", i), {31'b0, misalign}, 32'h0);
            end
            @(posedge clk); #1;
        end

        // Misaligned redirect (pc currently 0x4).
        idle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        @(posedge clk); #1;
        idle();
`ifdef PC_GEN_MISALIGN_EN
        check("mis_redirect pc", pc, 32'h100);
        check("mis_redirect pulse", {31'b0, misalign}, 32'h1);
`else
        check("mis_redirect pc", pc, 32'h102);
        check("mis_redirect pulse", {31'b0, misalign}, 32'h0);
`endif
        @(posedge clk); #1;
        check("mis_redirect pulse end", {31'b0, misalign}, 32'h0);
`ifdef PC_GEN_MISALIGN_EN
        check("mis_redirect next pc", pc, 32'h104);
`else
        check("mis_redirect next pc", pc, 32'h106);
`endif

        // Misaligned training target, then revisit the trained PC.
        upd_valid      = 1'b1;
        upd_pc         = 32'h40;
        upd_target     = 32'h502;
        upd_taken      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(posedge clk); #1;
        idle();
        check("mis_upd pc", pc, 32'h40);
`ifdef PC_GEN_MISALIGN_EN
        check("mis_upd pred_taken", {31'b0, pred_taken}, 32'h0);
        check("mis_upd pred_target", pred_target, 32'h44);
`else
        check("mis_upd pred_taken", {31'b0, pred_taken}, 32'h1);
        check("mis_upd pred_target", pred_target, 32'h502);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
